// File: rtl/fetch_unit_if.sv
// Fetch unit bus bundle: imem request/response, redirect, and decode-side queue head.
interface fetch_unit_if #(
  parameter int unsigned XLEN = 32
) ();
  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_rsp_valid;
  logic [31:0]     imem_rsp_data;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            inst_valid;
  logic            inst_ready;
  logic [31:0]     inst_data;
  logic [XLEN-1:0] inst_pc;

  // Fetch unit side
  modport master (
    output imem_req_valid, imem_req_addr,
    input  imem_req_ready,
    input  imem_rsp_valid, imem_rsp_data,
    input  redirect_valid, redirect_pc,
    output inst_valid, inst_data, inst_pc,
    input  inst_ready
  );

  // Memory / decode / branch-unit side
  modport slave (
    input  imem_req_valid, imem_req_addr,
    output imem_req_ready,
    output imem_rsp_valid, imem_rsp_data,
    output redirect_valid, redirect_pc,
    input  inst_valid, inst_data, inst_pc,
    output inst_ready
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch front end: owns fetch PC, issues in-order imem requests under
// queue-slot credit, tags responses with their PC, and squashes on redirect.
module fetch_unit #(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int unsigned     PC_STEP  = 4,
  parameter int unsigned     FQ_DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  fetch_unit_if.master io_bus
);

  localparam int unsigned AW = $clog2(FQ_DEPTH);
  localparam int unsigned CW = $clog2(FQ_DEPTH) + 1;
  localparam int unsigned SW = CW + 2;

  logic [XLEN-1:0] r_fetch_pc;
  logic [CW-1:0]   r_live_cnt;
  logic [CW-1:0]   r_drop_cnt;
  logic [CW-1:0]   r_q_count;
  logic [AW-1:0]   r_q_head;
  logic [AW-1:0]   r_q_tail;
  logic [AW-1:0]   r_t_head;
  logic [AW-1:0]   r_t_tail;
  logic [31:0]     r_q_data [FQ_DEPTH];
  logic [XLEN-1:0] r_q_pc   [FQ_DEPTH];
  logic [XLEN-1:0] r_t_pc   [FQ_DEPTH];

  logic [SW-1:0]   w_credit_sum;
  logic [CW-1:0]   w_pend;
  logic            w_redirect;
  logic            w_req_valid;
  logic            w_req_fire;
  logic            w_rsp_drop;
  logic            w_rsp_take;
  logic            w_rsp_any;
  logic            w_q_push;
  logic            w_inst_valid;
  logic            w_pop;

  // Credit: every outstanding request (live or to-be-dropped) holds a queue slot
  assign w_credit_sum = SW'(r_q_count) + SW'(r_live_cnt) + SW'(r_drop_cnt);
  assign w_pend       = r_drop_cnt + r_live_cnt;
  assign w_redirect   = io_bus.redirect_valid;
  assign w_req_valid  = !rst && !w_redirect && (w_credit_sum < SW'(FQ_DEPTH));
  assign w_req_fire   = w_req_valid && io_bus.imem_req_ready;

  // Stale responses are consumed first; a response with nothing pending is ignored
  assign w_rsp_drop   = io_bus.imem_rsp_valid && (r_drop_cnt != '0);
  assign w_rsp_take   = io_bus.imem_rsp_valid && (r_drop_cnt == '0) && (r_live_cnt != '0);
  assign w_rsp_any    = io_bus.imem_rsp_valid && (w_pend != '0);
  assign w_q_push     = w_rsp_take && !w_redirect;

  assign w_inst_valid = !rst && (r_q_count != '0);
  assign w_pop        = w_inst_valid && io_bus.inst_ready && !w_redirect;

  assign io_bus.imem_req_valid = w_req_valid;
  assign io_bus.imem_req_addr  = r_fetch_pc;
  assign io_bus.inst_valid     = w_inst_valid;
  assign io_bus.inst_data      = w_inst_valid ? r_q_data[r_q_head] : 32'h0;
  assign io_bus.inst_pc        = w_inst_valid ? r_q_pc[r_q_head]   : '0;

  // Fetch PC: redirect overrides, otherwise advance on each accepted request
  always_ff @(posedge clk) begin
    if (rst) begin
      r_fetch_pc <= RESET_PC;
    end else if (w_redirect) begin
      r_fetch_pc <= io_bus.redirect_pc;
    end else if (w_req_fire) begin
      r_fetch_pc <= r_fetch_pc + XLEN'(PC_STEP);
    end
  end

  // In-flight accounting: live requests become drops on redirect
  always_ff @(posedge clk) begin
    if (rst) begin
      r_live_cnt <= '0;
      r_drop_cnt <= '0;
    end else if (w_redirect) begin
      r_live_cnt <= '0;
      r_drop_cnt <= w_pend - CW'(w_rsp_any);
    end else begin
      r_live_cnt <= r_live_cnt + CW'(w_req_fire) - CW'(w_rsp_take);
      r_drop_cnt <= r_drop_cnt - CW'(w_rsp_drop);
    end
  end

  // Fetch queue pointers and occupancy; flushed on redirect
  always_ff @(posedge clk) begin
    if (rst || w_redirect) begin
      r_q_head  <= '0;
      r_q_tail  <= '0;
      r_q_count <= '0;
    end else begin
      if (w_q_push) r_q_tail <= r_q_tail + AW'(1);
      if (w_pop)    r_q_head <= r_q_head + AW'(1);
      r_q_count <= r_q_count + CW'(w_q_push) - CW'(w_pop);
    end
  end

  // PC-tag FIFO pointers; tags of squashed requests are discarded on redirect
  always_ff @(posedge clk) begin
    if (rst || w_redirect) begin
      r_t_head <= '0;
      r_t_tail <= '0;
    end else begin
      if (w_req_fire) r_t_tail <= r_t_tail + AW'(1);
      if (w_rsp_take) r_t_head <= r_t_head + AW'(1);
    end
  end

  // Storage: request PC tags on issue, {data, tag} into the queue on response
  always_ff @(posedge clk) begin
    if (w_req_fire) begin
      r_t_pc[r_t_tail] <= r_fetch_pc;
    end
    if (w_q_push) begin
      r_q_data[r_q_tail] <= io_bus.imem_rsp_data;
      r_q_pc[r_q_tail]   <= r_t_pc[r_t_head];
    end
  end

endmodule
